// File: rtl/softmax_vec_tx.sv
// softmax_vec_tx: buffers one vector, streams it to the max-finder, then replays it centered on the returned max
module softmax_vec_tx #(
  parameter int DW = 32,
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_full,
  input  logic          start,
  output logic          busy,
  output logic          tx_start,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic          rx_done,
  input  logic [DW-1:0] rx_max,
  output logic [DW-1:0] cen_data,
  output logic          cen_valid,
  input  logic          cen_ready,
  output logic          cen_last,
  output logic          done
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, ARM, STREAM, WAIT_MAX, CENTER, FIN} state_t;
  state_t st, nx;
  logic [DW-1:0] mem [N];
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [IW-1:0] idx;
  logic [DW-1:0] max_q, elem, sat;
  logic [DW:0] diff;
  logic got_max, last, wr_ok, tx_fire, cen_fire;
  assign elem = mem[idx];
  assign last = idx == IW'(N - 1);
  assign wr_ok = st == IDLE && wr_en && wcnt != CW'(N);
  assign wcnt_nx = st == FIN ? '0 : wr_ok ? wcnt + 1'b1 : wcnt;
  assign diff = {elem[DW-1], elem} - {max_q[DW-1], max_q};
  assign sat = diff[DW] != diff[DW-1] ? (diff[DW] ? MINV : MAXV) : diff[DW-1:0];
  assign busy = st != IDLE;
  assign tx_start = st == ARM;
  assign tx_valid = st == STREAM;
  assign tx_data = tx_valid ? elem : '0;
  assign cen_valid = st == CENTER;
  assign cen_data = cen_valid ? sat : '0;
  assign cen_last = cen_valid && last;
  assign done = st == FIN;
  assign tx_fire = tx_valid && tx_ready;
  assign cen_fire = cen_valid && cen_ready;
  always_comb begin
    nx = st;
    case (st)
      IDLE:     nx = start && wr_full ? ARM : IDLE;
      ARM:      nx = STREAM;
      STREAM:   nx = tx_fire && last ? (got_max ? CENTER : WAIT_MAX) : STREAM;
      WAIT_MAX: nx = got_max ? CENTER : WAIT_MAX;
      CENTER:   nx = cen_fire && last ? FIN : CENTER;
      FIN:      nx = IDLE;
      default:  nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      wcnt <= '0;
      wr_full <= 1'b0;
      idx <= '0;
      max_q <= '0;
      got_max <= 1'b0;
    end else begin
      st <= nx;
      wcnt <= wcnt_nx;
      wr_full <= wcnt_nx == CW'(N);
      if (st == ARM)
        idx <= '0;
      else if (tx_fire || cen_fire)
        idx <= last ? '0 : idx + 1'b1;
      if (st == FIN)
        got_max <= 1'b0;
      else if (rx_done && st != IDLE) begin
        got_max <= 1'b1;
        max_q <= rx_max;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wcnt[IW-1:0]] <= wr_data;
  end
endmodule

// File: tb/tb_softmax_vec_tx.sv
// tb_softmax_vec_tx: scoreboard bench for softmax_vec_tx with directed hand-computed vectors
module tb_softmax_vec_tx;
  logic clk = 1'b0;
  logic rst, wr_en, start, tx_ready, rx_done, cen_ready;
  logic [7:0] wr_data, rx_max;
  logic wr_full, busy, tx_start, tx_valid, cen_valid, cen_last, done;
  logic [7:0] tx_data, cen_data;
  logic [7:0] tx_q[$];
  logic [8:0] cen_q[$];
  int total = 0, pass = 0;
  int done_cnt = 0, start_cnt = 0, tx_cnt = 0, cen_cnt = 0;
  logic bp = 1'b0;
  logic tx_hold = 1'b0, cen_hold = 1'b0;
  logic [7:0] tx_prev;
  logic [8:0] cen_prev;
  softmax_vec_tx #(.DW(8), .N(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .start(start), .busy(busy), .tx_start(tx_start), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_done(rx_done), .rx_max(rx_max),
    .cen_data(cen_data), .cen_valid(cen_valid), .cen_ready(cen_ready),
    .cen_last(cen_last), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    tx_ready = 1'b1;
    cen_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = bp ? pat[ph] : 1'b1;
      cen_ready = bp ? pat[ph] : 1'b1;
      ph = (ph + 1) % 4;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      tx_hold = 1'b0;
      cen_hold = 1'b0;
    end else begin
      if (tx_valid && tx_hold) chk("tx_stable", tx_data, tx_prev);
      if (cen_valid && cen_hold) chk("cen_stable", {cen_last, cen_data}, cen_prev);
      tx_hold = tx_valid && !tx_ready;
      tx_prev = tx_data;
      cen_hold = cen_valid && !cen_ready;
      cen_prev = {cen_last, cen_data};
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        if (tx_q.size() == 0) begin
          total++;
          $display("FAIL tx_extra: got beat %0h want none", tx_data);
        end else chk("tx_data", tx_data, tx_q.pop_front());
      end
      if (cen_valid && cen_ready) begin
        cen_cnt++;
        if (cen_q.size() == 0) begin
          total++;
          $display("FAIL cen_extra: got beat %0h want none", cen_data);
        end else chk("cen_last_data", {cen_last, cen_data}, cen_q.pop_front());
      end
      if (done) done_cnt++;
      if (tx_start) start_cnt++;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask
  task automatic wr4(input logic [31:0] v);
    for (int i = 0; i < 4; i++) wr(v[8*(3-i) +: 8]);
  endtask
  task automatic go(input logic [31:0] tv, input logic [31:0] cv, input logic [7:0] mx, input bit early);
    int d0, s0, t0, c0;
    bit sent;
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(tv[8*(3-i) +: 8]);
      cen_q.push_back({i == 3, cv[8*(3-i) +: 8]});
    end
    d0 = done_cnt;
    s0 = start_cnt;
    t0 = tx_cnt;
    c0 = cen_cnt;
    sent = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("tx_start_pulse", {31'd0, tx_start}, 1);
    chk("busy_arm", {31'd0, busy}, 1);
    for (int c = 0; c < 200 && done_cnt == d0; c++) begin
      rx_done = 1'b0;
      if (!sent && tx_q.size() <= (early ? 2 : 0)) begin
        rx_done = 1'b1;
        rx_max = mx;
        sent = 1'b1;
      end
      cyc();
    end
    rx_done = 1'b0;
    cyc();
    cyc();
    chk("done_pulses", done_cnt - d0, 1);
    chk("tx_start_pulses", start_cnt - s0, 1);
    chk("tx_beats", tx_cnt - t0, 4);
    chk("cen_beats", cen_cnt - c0, 4);
    chk("wr_full_after", {31'd0, wr_full}, 0);
    chk("busy_after", {31'd0, busy}, 0);
  endtask
  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    start = 1'b0;
    rx_done = 1'b0;
    rx_max = '0;
    repeat (3) cyc();
    chk("reset_outs", {tx_start, tx_valid, tx_data, cen_data, cen_valid, cen_last, done, busy, wr_full}, 0);
    rst = 1'b0;
    cyc();
    wr4({8'd3, 8'hF9, 8'd12, 8'd0});
    chk("wr_full_set", {31'd0, wr_full}, 1);
    go({8'd3, 8'hF9, 8'd12, 8'd0}, {8'hF7, 8'hED, 8'h00, 8'hF4}, 8'd12, 1'b0);
    wr4({8'h80, 8'h7F, 8'h00, 8'h05});
    go({8'h80, 8'h7F, 8'h00, 8'h05}, {8'h80, 8'h00, 8'h81, 8'h86}, 8'h7F, 1'b0);
    bp = 1'b1;
    wr4({8'd3, 8'hF9, 8'd12, 8'd0});
    go({8'd3, 8'hF9, 8'd12, 8'd0}, {8'hF7, 8'hED, 8'h00, 8'hF4}, 8'd12, 1'b0);
    bp = 1'b0;
    cyc();
    wr(8'd1);
    wr(8'd2);
    wr(8'd3);
    chk("wr_full_3", {31'd0, wr_full}, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("gated_busy", {31'd0, busy}, 0);
    cyc();
    chk("gated_idle", {busy, tx_start, tx_valid}, 0);
    wr(8'd4);
    wr(8'h63);
    chk("wr_full_4", {31'd0, wr_full}, 1);
    go({8'd1, 8'd2, 8'd3, 8'd4}, {8'hFD, 8'hFE, 8'hFF, 8'h00}, 8'd4, 1'b0);
    wr4({8'd3, 8'hF9, 8'd12, 8'd0});
    go({8'd3, 8'hF9, 8'd12, 8'd0}, {8'hF7, 8'hED, 8'h00, 8'hF4}, 8'd12, 1'b1);
    begin
      int t0;
      wr4({8'd7, 8'd8, 8'd9, 8'd10});
      for (int i = 0; i < 4; i++) tx_q.push_back(8'd7 + 8'(i));
      t0 = tx_cnt;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int c = 0; c < 50 && tx_cnt - t0 < 2; c++) cyc();
      chk("beats_before_rst", tx_cnt - t0, 2);
      rst = 1'b1;
      #1;
      chk("midrst_outs", {tx_start, tx_valid, tx_data, cen_data, cen_valid, cen_last, done, busy, wr_full}, 0);
      cyc();
      tx_q.delete();
      cen_q.delete();
      rst = 1'b0;
      cyc();
    end
    wr4({8'd10, 8'd20, 8'hE2, 8'd5});
    go({8'd10, 8'd20, 8'hE2, 8'd5}, {8'hF6, 8'h00, 8'hCE, 8'hF1}, 8'd20, 1'b0);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("cen_q_empty", cen_q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/softmax_vec_tx.md
Name: softmax_vec_tx

Overview:
- Source-side counterpart of the softmax max-finder. It buffers one N-element signed vector and streams it to the max-finder's start/din/din_valid interface.
- It waits for the max-finder's done/max_out, then replays the same vector as centered values x[i] − max on a second valid/ready stream.
- It sits between the vector producer (loader/DMA) and the max-finder, and also feeds the downstream exp stage.

Parameters:
- DW, 32, element width in bits (signed two's complement).
- N, 32, vector length; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- wr_en  in  1  load-side write strobe
- wr_data  in  DW  load-side element (signed)
- wr_full  out  1  high when the buffer holds N elements
- start  in  1  begin a transaction (honoured only in IDLE with wr_full=1)
- busy  out  1  high in every state except IDLE
- tx_start  out  1  one-cycle pulse to the max-finder's start
- tx_data  out  DW  element to the max-finder's din
- tx_valid  out  1  to the max-finder's din_valid
- tx_ready  in  1  consumer ready; tie to 1 for the current max-finder
- rx_done  in  1  max-finder done pulse
- rx_max  in  DW  max-finder max_out (signed), sampled when rx_done=1
- cen_data  out  DW  centered element x[i] − max, saturated
- cen_valid  out  1  centered stream valid
- cen_ready  in  1  centered stream ready
- cen_last  out  1  high with the final centered element
- done  out  1  one-cycle pulse when the transaction completes

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; write count 0; index 0; max register 0; done-latch 0. Reset mid-operation aborts immediately and discards the buffered vector.
- Buffer: N×DW register array plus write counter wcnt (0..N).
  - In IDLE, each wr_en with wcnt<N writes buf[wcnt] and increments wcnt.
  - wr_en with wcnt=N is dropped.
  - wr_en outside IDLE is dropped.
  - wr_full = (wcnt==N), registered.
- FSM: IDLE → ARM → STREAM → WAIT_MAX → CENTER → FIN → IDLE.
  - IDLE: start && wr_full → ARM. start with wr_full=0 is ignored, with no state change.
  - ARM: tx_start=1 for exactly this cycle; idx←0; → STREAM.
  - STREAM:
    - tx_valid=1 and tx_data=buf[idx], driven combinationally from the registered idx.
    - On tx_valid && tx_ready: idx increments.
    - When the transfer completes at idx=N−1: idx←0 and → WAIT_MAX.
    - tx_valid/tx_data stay stable while tx_ready=0.
    - With tx_ready=1, the N elements occupy N consecutive cycles, the first in the cycle after tx_start.
  - WAIT_MAX: waits for the done-latch; when set, → CENTER.
  - CENTER:
    - cen_valid=1; cen_data=sat(buf[idx] − max_reg); cen_last=(idx==N−1).
    - Advances on cen_valid && cen_ready.
    - On the final transfer → FIN.
    - Outputs stay stable under backpressure.
  - FIN: done=1 for one cycle; wcnt←0; done-latch←0; → IDLE. The same vector cannot be replayed without reloading.
- rx_done handling:
  - rx_done in any non-IDLE state sets the done-latch and loads max_reg←rx_max. This includes rx_done arriving during STREAM or in the same cycle as the last tx beat.
  - rx_done in IDLE is ignored.
  - A second rx_done before FIN overwrites max_reg.
- Arithmetic:
  - The difference is computed at DW+1 bits.
  - Results below −2^(DW−1) saturate to −2^(DW−1); results above 2^(DW−1)−1 saturate to 2^(DW−1)−1.
  - No wrap-around is permitted.
- Latency, with both readies high: start → tx_start 1 cycle; tx_start → last tx beat N cycles; rx_done → first cen beat ≤2 cycles; last cen beat → done 1 cycle.

Test Plan:
- N=4, DW=8. Load [3,−7,12,0]; start; tx_ready=1 → tx_start pulse; tx_data 3,−7,12,0 on 4 consecutive cycles. Drive rx_done with rx_max=12 → cen_data −9,−19,0,−12; cen_last only on −12; done pulses once; wr_full returns 0.
- Saturation: load [−128,127,0,5]; rx_max=127 → cen_data −128 (saturated from −255), 0, −127, −122.
- Backpressure: toggle tx_ready and cen_ready 1,0,0,1,… → tx_data and cen_data held stable while stalled; the sequence is unchanged; beat counts are exactly 4 each.
- Start gating: load 3 elements, pulse start → stays IDLE, busy=0. Write a 4th, pulse start → ARM. A 5th write while wr_full=1 is dropped and does not appear in tx_data.
- Early rx_done: assert rx_done (rx_max=12) during the 3rd tx beat → no hang; CENTER entered right after the last beat with correct outputs.
- Reset mid-STREAM: assert rst after 2 tx beats → all outputs 0, IDLE, wr_full=0. Reload and start → clean full transaction.
